input_debouncer: RTL
====================

// Module: input_debouncer
// PURPOSE
//  Conditions a raw, asynchronous, bouncy input, such as a switch or external pin, into a clean level.
//  Sits directly upstream of edge_detector and drives its a_i.
//  Pipeline: SYNC_STAGES-flop synchroniser -> 4-state debounce FSM -> registered level out.
//  Guarantees the edge detector sees one transition per real input change.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    consecutive stable synced cycles required to accept a new level (>=1)
//  SYNC_STAGES      2     synchroniser depth (>=2)
//  RESET_LEVEL      1'b0  value of synchroniser flops and db_out during/after reset
//  Out-of-range values: elaboration error ($error in generate check).
// PORTS
//  clk             input   1  single clock; all state on posedge
//  reset           input   1  synchronous, active-low reset (0 = in reset)
//  raw_i           input   1  raw asynchronous input
//  db_out          output  1  debounced level; feeds edge_detector a_i
//  busy_out        output  1  high while FSM is in a WAIT state (candidate change pending)
//  glitch_cnt_out  output  8  aborted-transition count; present only with macro, see CONFIGURATION
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - sync chain all = RESET_LEVEL; db_out = RESET_LEVEL.
//   - busy_out = 0; counter = 0; glitch_cnt_out = 0.
//   - state = STABLE_HI if RESET_LEVEL else STABLE_LO.
//   - Overrides any in-flight WAIT; no partial count is retained.
//  sync = last synchroniser stage; raw_i is never used combinationally.
//  Counter cnt: width $clog2(DEBOUNCE_CYCLES+1), unsigned, never wraps.
//  FSM states:
//   STABLE_LO (db_out=0): sync==1 -> WAIT_HI, cnt=1; else stay, cnt=0.
//   WAIT_HI   (db_out=0):
//    - sync==0 -> STABLE_LO, cnt=0, glitch++.
//    - sync==1 && cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, db_out<=1, cnt=0.
//    - else cnt++.
//   STABLE_HI / WAIT_LO: mirror of the above with polarities swapped.
//  DEBOUNCE_CYCLES==1:
//   - STABLE_x accepts immediately on first differing sync sample; WAIT states are never entered.
//   - busy_out never asserts.
//  busy_out: registered; 1 exactly when state is WAIT_HI or WAIT_LO.
//  Latency: raw_i changes before edge k and is held -> db_out updates at edge
//   k+SYNC_STAGES+DEBOUNCE_CYCLES-1, visible in cycle after. Total = SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//  Any sync reversal during WAIT fully restarts qualification; a bounce never produces two db_out changes.
//  db_out changes at most once per DEBOUNCE_CYCLES cycles; it is glitch-free (direct flop output).
//  Simultaneous reset and input change: reset wins.
// CONFIGURATION
//  DEBOUNCER_GLITCH_CNT_EN defined:
//   - glitch_cnt_out port exists.
//   - Increments by 1 on each WAIT -> STABLE abort.
//   - Saturates at 8'hFF; no wrap. Cleared only by reset.
//  DEBOUNCER_GLITCH_CNT_EN undefined:
//   - Port and counter logic absent; all other behaviour identical.
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0 unless noted)
//  1 Reset: reset=0 for 2 cycles, raw_i=1 -> db_out=0, busy_out=0, glitch_cnt_out=0; then still db_out=0 until qualified.
//  2 Clean rise: raw_i 0->1 held 12 cycles -> db_out rises exactly 6 cycles after change; busy_out high 3 cycles; one edge.
//  3 Glitch: raw_i=1 for 2 cycles then 0 -> db_out stays 0; glitch_cnt_out=1.
//  4 Bounce: raw_i 1,0,1,1,0 then 1 held -> single db_out 0->1, 6 cycles after final rise; glitch_cnt_out=2.
//  5 Reset mid-WAIT_LO: db_out=1, raw_i=0 for 3 cycles, reset pulse -> db_out=0, busy_out=0, cnt=0 next cycle.
//  6 Boundary DEBOUNCE_CYCLES=1: raw_i toggles every 3 cycles -> db_out follows with 3-cycle latency; busy_out never 1.

Source files
------------

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Turns a raw, asynchronous, bouncy input (switch, external pin) into a clean
// level for the downstream edge_detector. A new input level is accepted only
// after it has been seen on the synchronised signal for DEBOUNCE_CYCLES
// consecutive clocks. Any reversal while qualifying throws the candidate
// away, so one real input change yields exactly one db_out transition.
//
// Pipeline: SYNC_STAGES-flop synchroniser -> 4-state debounce FSM ->
//           registered level out.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synced cycles to accept a level (>=1)
//   SYNC_STAGES      synchroniser depth (>=2)
//   RESET_LEVEL      synchroniser flops and db_out value during/after reset
//
// Ports
//   clk             in   1  single clock, all state on posedge
//   reset           in   1  synchronous, active-low reset (0 = in reset)
//   raw_i           in   1  raw asynchronous input (only ever registered)
//   db_out          out  1  debounced level, direct flop output
//   busy_out        out  1  high while a candidate change is being qualified
//   glitch_cnt_out  out  8  saturating count of aborted candidates
//                           (only when DEBOUNCER_GLITCH_CNT_EN is defined)
//
// Configuration macro
//   DEBOUNCER_GLITCH_CNT_EN  adds glitch_cnt_out and its counter. Without it
//                            the port and logic are absent; everything else
//                            behaves identically.
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter int   SYNC_STAGES     = 2,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       raw_i,
   output logic       db_out,
   output logic       busy_out
`ifdef DEBOUNCER_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt_out
`endif
);

   // Counter only ever holds 0..DEBOUNCE_CYCLES-1, so this width never wraps.
   localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   // With a one-cycle window the first differing sample already qualifies,
   // so the WAIT states are skipped entirely.
   localparam logic              IMMEDIATE = (DEBOUNCE_CYCLES == 1);

   generate
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
         $error("input_debouncer: DEBOUNCE_CYCLES must be >= 1");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("input_debouncer: SYNC_STAGES must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'd0,
      ST_WAIT_HI   = 2'd1,
      ST_STABLE_HI = 2'd2,
      ST_WAIT_LO   = 2'd3
   } state_t;

   localparam state_t ST_RESET = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_db;
   logic                   r_busy;

   // Oldest synchroniser stage is the only view of raw_i the FSM ever gets.
   assign w_sync = r_sync[SYNC_STAGES-1];

   // Synchroniser shift chain: raw_i enters at bit 0, exits at the top bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
      end
   end

   // Debounce FSM: qualifies candidate levels and owns db_out / busy_out.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_RESET;
         r_cnt   <= CNT_ZERO;
         r_db    <= RESET_LEVEL;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_STABLE_LO: begin
               if (w_sync) begin
                  if (IMMEDIATE) begin
                     r_state <= ST_STABLE_HI;
                     r_db    <= 1'b1;
                     r_cnt   <= CNT_ZERO;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_WAIT_HI;
                     r_db    <= 1'b0;
                     r_cnt   <= CNT_ONE;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= ST_STABLE_LO;
                  r_db    <= 1'b0;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end
            end

            ST_WAIT_HI: begin
               if (!w_sync) begin
                  // Reversal: drop the candidate completely.
                  r_state <= ST_STABLE_LO;
                  r_db    <= 1'b0;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else if (r_cnt >= CNT_LAST) begin
                  // ">=" rather than "==" so a corrupted count still exits.
                  r_state <= ST_STABLE_HI;
                  r_db    <= 1'b1;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_WAIT_HI;
                  r_db    <= 1'b0;
                  r_cnt   <= r_cnt + CNT_ONE;
                  r_busy  <= 1'b1;
               end
            end

            ST_STABLE_HI: begin
               if (!w_sync) begin
                  if (IMMEDIATE) begin
                     r_state <= ST_STABLE_LO;
                     r_db    <= 1'b0;
                     r_cnt   <= CNT_ZERO;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_WAIT_LO;
                     r_db    <= 1'b1;
                     r_cnt   <= CNT_ONE;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= ST_STABLE_HI;
                  r_db    <= 1'b1;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end
            end

            ST_WAIT_LO: begin
               if (w_sync) begin
                  r_state <= ST_STABLE_HI;
                  r_db    <= 1'b1;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else if (r_cnt >= CNT_LAST) begin
                  r_state <= ST_STABLE_LO;
                  r_db    <= 1'b0;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_WAIT_LO;
                  r_db    <= 1'b1;
                  r_cnt   <= r_cnt + CNT_ONE;
                  r_busy  <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_RESET;
               r_db    <= RESET_LEVEL;
               r_cnt   <= CNT_ZERO;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign db_out   = r_db;
   assign busy_out = r_busy;

`ifdef DEBOUNCER_GLITCH_CNT_EN
   logic [7:0] r_glitch_cnt;
   logic       w_abort;

   // Saturating increment so a noisy pin can never make the count wrap.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return 8'hFF;
      end else begin
         return value + 8'd1;
      end
   endfunction

   // An abort is exactly the WAIT -> STABLE transition back to the old level.
   assign w_abort = ((r_state == ST_WAIT_HI) && !w_sync) ||
                    ((r_state == ST_WAIT_LO) &&  w_sync);

   // Aborted-candidate counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_glitch_cnt <= 8'h00;
      end else if (w_abort) begin
         r_glitch_cnt <= sat_inc8(r_glitch_cnt);
      end else begin
         r_glitch_cnt <= r_glitch_cnt;
      end
   end

   assign glitch_cnt_out = r_glitch_cnt;
`endif

endmodule
